cpu_btn_entry: RTL and testbench

- Input-side companion to the register display path: lets the user key a 16-bit hex value into the softcore using the four active-low board buttons.
- Each button is synchronised and debounced; a small FSM edits one nibble at a time and issues a one-cycle commit strobe.
- entry_value drives the 7-segment display path during editing; committed_value and entry_valid feed the CPU (PC load or memory poke).

---
 rtl/cpu_btn_entry.sv | 158 +++++++++++++++
 tb/tb_cpu_btn_entry.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_btn_entry.sv
// rtl/cpu_btn_entry.sv - four-button hex entry: sync, debounce, nibble-edit FSM, commit strobe (optional CPU_BTN_AUTOREPEAT_EN)
module cpu_btn_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_n,
  output logic [15:0] entry_value,
  output logic [15:0] committed_value,
  output logic [1:0]  cursor,
  output logic        entry_valid,
  output logic        editing,
  output logic [3:0]  btn_level
);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the debounce and repeat counters cannot honour.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("cpu_btn_entry: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  state_t           state;
  logic [3:0]       sync1, sync2;
  logic [3:0]       sync;
  logic [CNT_W-1:0] db_cnt [4];
  logic [3:0]       btn_level_d;
  logic [3:0]       press;
  logic             do_inc;

  assign sync = ~sync2;

  function automatic logic [15:0] inc_nibble(input logic [15:0] v, input logic [1:0] c);
    logic [15:0] r;
    r = v;
    r[{c, 2'b00} +: 4] = v[{c, 2'b00} +: 4] + 4'd1;
    return r;
  endfunction

  // Two-flop synchroniser; idles at 1 because the buttons are active low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level <= 4'b0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= ~btn_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered one-cycle press events on debounced rising edges only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level_d <= 4'b0;
      press       <= 4'b0;
    end else begin
      btn_level_d <= btn_level;
      press       <= btn_level & ~btn_level_d;
    end
  end

`ifdef CPU_BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             rpt_run;
  logic             rpt_fire;

  // Repeat only counts while button 0 is held with no fresh event and no commit in flight.
  always_comb begin
    rpt_run  = btn_level[0] && (state != S_COMMIT) && (press == 4'b0);
    rpt_fire = rpt_run && (rpt_cnt == (rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1)));
    do_inc   = press[0] || rpt_fire;
  end

  // Hold timer: restarts on any press, release or commit; first interval is the longer delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (!rpt_run) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign do_inc = press[0];
`endif

  // Edit FSM: one prioritised action per cycle, clear > commit > next > increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      entry_value     <= 16'h0;
      committed_value <= 16'h0;
      cursor          <= 2'd0;
      entry_valid     <= 1'b0;
      editing         <= 1'b0;
    end else begin
      entry_valid <= 1'b0;
      if (state == S_COMMIT) begin
        state   <= S_IDLE;
        editing <= 1'b0;
      end else if (press[3]) begin
        entry_value <= 16'h0;
        cursor      <= 2'd0;
        if (state == S_EDIT || committed_value != 16'h0) begin
          state   <= S_EDIT;
          editing <= 1'b1;
        end
      end else if (press[2]) begin
        committed_value <= entry_value;
        cursor          <= 2'd0;
        entry_valid     <= 1'b1;
        editing         <= 1'b0;
        state           <= S_COMMIT;
      end else if (press[1]) begin
        cursor <= cursor + 2'd1;
      end else if (do_inc) begin
        entry_value <= inc_nibble(entry_value, cursor);
        state       <= S_EDIT;
        editing     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_btn_entry.sv
// tb/tb_cpu_btn_entry.sv - randomized model-checked bench for cpu_btn_entry
module tb_cpu_btn_entry;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  btn_n;
  logic [15:0] entry_value, committed_value;
  logic [1:0]  cursor;
  logic        entry_valid, editing;
  logic [3:0]  btn_level;

  int total = 0;
  int bad   = 0;

  cpu_btn_entry #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(rst),
    .btn_n(btn_n),
    .entry_value(entry_value),
    .committed_value(committed_value),
    .cursor(cursor),
    .entry_valid(entry_valid),
    .editing(editing),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples age two cycles, a level flips once the synced
  // input has disagreed for D samples in a row, a rising level becomes an event
  // one cycle later, and that event is acted on the cycle after.
  logic [3:0]  m_raw1, m_raw2, m_level, m_level_d, m_press;
  int          m_run [4];
  logic [15:0] m_entry, m_committed;
  int          m_cursor;
  logic        m_editing, m_in_commit;
  int          m_age, m_lim;

  always @(posedge clk or posedge rst) begin
    logic [3:0] s;
    logic       rpt;
    int         sh;
    if (rst) begin
      m_raw1 = 4'hF; m_raw2 = 4'hF; m_level = 0; m_level_d = 0; m_press = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_entry = 0; m_committed = 0; m_cursor = 0; m_editing = 0; m_in_commit = 0;
      m_age = 0; m_lim = RD;
    end else begin
      rpt = 1'b0;
`ifdef CPU_BTN_AUTOREPEAT_EN
      if (m_level[0] && !m_in_commit && m_press == 0) begin
        m_age++;
        if (m_age == m_lim) begin
          rpt = 1'b1; m_age = 0; m_lim = RP;
        end
      end else begin
        m_age = 0; m_lim = RD;
      end
`endif
      if (m_in_commit) begin
        m_in_commit = 0;
      end else if (m_press[3]) begin
        m_entry = 0; m_cursor = 0;
        if (m_editing || m_committed != 0) m_editing = 1;
      end else if (m_press[2]) begin
        m_committed = m_entry; m_cursor = 0; m_in_commit = 1; m_editing = 0;
      end else if (m_press[1]) begin
        m_cursor = (m_cursor + 1) % 4;
      end else if (m_press[0] || rpt) begin
        sh = 4 * m_cursor;
        m_entry = (m_entry & ~(16'hF << sh)) | (16'((((m_entry >> sh) & 16'hF) + 1) % 16) << sh);
        m_editing = 1;
      end
      m_press   = m_level & ~m_level_d;
      m_level_d = m_level;
      s = ~m_raw2;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_level[i] = ~m_level[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_raw2 = m_raw1;
      m_raw1 = btn_n;
    end
  end

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    chk("entry_value", entry_value, m_entry);
    chk("committed_value", committed_value, m_committed);
    chk("cursor", cursor, m_cursor);
    chk("entry_valid", entry_valid, m_in_commit);
    chk("editing", editing, m_editing);
    chk("btn_level", btn_level, m_level);
  end

  task automatic press_btn(input int i);
    btn_n = 4'hF;
    btn_n[i] = 1'b0;
    repeat (6) @(negedge clk);
    btn_n = 4'hF;
    repeat (7) @(negedge clk);
  endtask

  task automatic press_n(input int i, input int n);
    for (int k = 0; k < n; k++) press_btn(i);
  endtask

  int valid_cnt;

  initial begin
    rst = 1'b1;
    btn_n = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset entry", entry_value, 0);
    chk("reset level", btn_level, 0);

    // Latency: edge 0 samples the press, entry changes after edge 7.
    btn_n = 4'b1110;
    repeat (7) @(negedge clk);
    chk("latency pre", entry_value, 16'h0000);
    @(negedge clk);
    chk("latency hit", entry_value, 16'h0001);
    chk("latency editing", editing, 1);
    repeat (2) @(negedge clk);
    btn_n = 4'hF;
    repeat (10) @(negedge clk);
    chk("single inc", entry_value, 16'h0001);

    // Short glitch on button 0 must be ignored.
    btn_n = 4'b1110;
    repeat (2) @(negedge clk);
    btn_n = 4'hF;
    repeat (10) @(negedge clk);
    chk("glitch entry", entry_value, 16'h0001);
    chk("glitch level", btn_level, 0);

    // Nibble wrap with no carry, then cursor wrap.
    press_btn(3);
    press_btn(1);
    press_n(0, 15);
    chk("nibble F", entry_value, 16'h00F0);
    press_btn(0);
    chk("nibble wrap", entry_value, 16'h0000);
    chk("wrap cursor", cursor, 1);
    press_n(1, 3);
    chk("cursor wrap", cursor, 0);

    // Key in C0DE and commit.
    press_btn(3);
    press_n(0, 14);
    press_btn(1);
    press_n(0, 13);
    press_btn(1);
    press_btn(1);
    press_n(0, 12);
    chk("pre-commit entry", entry_value, 16'hC0DE);
    valid_cnt = 0;
    btn_n = 4'b1011;
    repeat (6) @(negedge clk);
    btn_n = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (entry_valid) valid_cnt++;
    end
    chk("valid pulses", valid_cnt, 1);
    chk("committed", committed_value, 16'hC0DE);
    chk("commit cursor", cursor, 0);
    chk("commit editing", editing, 0);

    // Coincident clear and increment: clear wins, increment dropped.
    press_btn(0);
    chk("pre-clear", entry_value, 16'hC0DF);
    btn_n = 4'b0110;
    repeat (6) @(negedge clk);
    btn_n = 4'hF;
    repeat (7) @(negedge clk);
    chk("clear wins", entry_value, 16'h0000);
    chk("clear editing", editing, 1);

    // Randomized button activity.
    for (int k = 0; k < 150; k++) begin
      btn_n = 4'($urandom);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    btn_n = 4'hF;
    repeat (12) @(negedge clk);
    press_btn(1);
    press_btn(0);
    press_btn(2);

    // Asynchronous reset in the middle of a debounce.
    btn_n = 4'b1110;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async entry", entry_value, 0);
    chk("async committed", committed_value, 0);
    chk("async cursor", cursor, 0);
    chk("async valid", entry_valid, 0);
    chk("async editing", editing, 0);
    chk("async level", btn_level, 0);
    btn_n = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Long hold on button 0 (~40 cycles past the press event).
    btn_n = 4'b1110;
    repeat (42) @(negedge clk);
    btn_n = 4'hF;
    repeat (30) @(negedge clk);
`ifdef CPU_BTN_AUTOREPEAT_EN
    chk("hold repeats", entry_value, 16'h0004);
`else
    chk("hold single", entry_value, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
